// File: rtl/ambm_arbiter.sv
// ambm_arbiter: round-robin arbiter feeding a single-slot alpha-max-plus-beta-min
// magnitude estimator (|z| ~= max + min/4), with saturation on overflow.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   req_valid/req_ready   - per-requester handshake; req_ready is a combinational one-hot grant
//   req_a, req_b          - packed operands, requester i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready   - result handshake
//   out_result/out_id/out_ovf - estimate, owning requester, saturation flag
//   busy                  - high whenever an operation is in flight
module ambm_arbiter #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [$clog2(N_REQ)-1:0]   out_id,
    output logic                       out_ovf,
    output logic                       busy
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic              ovf_q, ovf_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic [WIDTH-1:0]  op_max;
    logic [WIDTH-1:0]  op_min;
    logic [WIDTH:0]    sum;

    // Round-robin search starting just after the last accepted requester.
    // k = N_REQ wraps back to ptr itself, so it is searched last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'(ptr_q + ID_W'(k));
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Magnitude estimate from the captured operand pair.
    always_comb begin
        op_max = (a_q > b_q) ? a_q : b_q;
        op_min = (a_q > b_q) ? b_q : a_q;
        sum    = (WIDTH+1)'(op_max) + (WIDTH+1)'(op_min >> 2);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        res_d     = res_q;
        out_id_d  = out_id_q;
        ovf_d     = ovf_q;
        req_ready = '0;

        case (state_q)
            IDLE: begin
                // Grant is gated by reset so nothing is offered while reset is held.
                if (grant_found && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    a_d     = req_a[grant_idx*WIDTH +: WIDTH];
                    b_d     = req_b[grant_idx*WIDTH +: WIDTH];
                    id_d    = grant_idx;
                    ptr_d   = grant_idx;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (sum[WIDTH]) begin
                    res_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    res_d = sum[WIDTH-1:0];
                    ovf_d = 1'b0;
                end
                out_id_d = id_q;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= ID_W'(N_REQ - 1);
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            res_q    <= '0;
            out_id_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            res_q    <= res_d;
            out_id_q <= out_id_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = res_q;
    assign out_id     = out_id_q;
    assign out_ovf    = ovf_q;

endmodule

// File: doc/ambm_arbiter.md
AMBM_ARBITER -- requirements
Module: ambm_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 27, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, N_REQ bits: bit i high means requester i presents an operand pair.
REQ-006 The block SHALL have port req_ready, output, N_REQ bits: one-hot or zero; bit i high means requester i is granted this cycle.
REQ-007 The block SHALL have port req_a, input, N_REQ*WIDTH bits: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port req_b, input, N_REQ*WIDTH bits: operand B, packed the same way as req_a.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_result, out_id and out_ovf are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the output.
REQ-011 The block SHALL have port out_result, output, WIDTH bits: the alpha-max-plus-beta-min magnitude estimate.
REQ-012 The block SHALL have port out_id, output, log2(N_REQ) bits: index of the requester that owns the result.
REQ-013 The block SHALL have port out_ovf, output, 1 bit: the result was saturated.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement states IDLE, CALC and DONE, and SHALL hold at most one operation in flight.
REQ-016 In IDLE with any req_valid bit high, the block SHALL assert exactly one req_ready bit, combinationally, for the winner of the round-robin search.
REQ-017 The round-robin search SHALL begin at index ptr+1 and wrap modulo N_REQ; ptr is the index of the last accepted requester.
REQ-018 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high; on that edge the block SHALL capture A, B and i, set ptr to i, and go to CALC.
REQ-019 In CALC, max is A if A > B (unsigned), otherwise B; min is the other operand; for A equal to B, max and min are both that value.
REQ-020 In CALC, the block SHALL compute sum = max + (min >> 2) at WIDTH+1 bits.
REQ-021 If sum bit WIDTH is set, the block SHALL register out_result as all-ones and out_ovf as 1; otherwise out_result is sum[WIDTH-1:0] and out_ovf is 0.
REQ-022 On that same CALC edge the block SHALL register out_id and go to DONE; out_valid SHALL be high exactly while in DONE.
REQ-023 Latency SHALL be two cycles from the accepting edge to the first cycle in which out_valid is high.
REQ-024 In DONE, out_result, out_id and out_ovf SHALL hold stable until out_ready is high; that edge returns the block to IDLE.
REQ-025 req_ready SHALL be all zeros in CALC and DONE; new requests SHALL be served no earlier than the cycle after the DONE handshake.
REQ-026 Requesters that are not granted SHALL NOT be dropped; their inputs are ignored until they are granted.
REQ-027 A req_valid bit falling in IDLE before a transfer SHALL simply remove that requester from the current search, with no state change.
REQ-028 If no req_valid bit is high in IDLE, the block SHALL remain in IDLE and ptr SHALL be unchanged.

Reset
REQ-029 While reset is high, the block SHALL go to IDLE immediately (asynchronously), independent of clk.
REQ-030 Reset SHALL set req_ready to 0, out_valid to 0, out_result to 0, out_id to 0, out_ovf to 0, busy to 0 and ptr to N_REQ-1, so requester 0 has first priority.
REQ-031 Reset asserted in CALC or DONE SHALL discard the in-flight operation, and no output SHALL ever be presented for it.

Verification
REQ-032 Bench: req 0 valid with A=100, B=40, out_ready=1 -> req_ready=0001 in the accept cycle; two cycles later out_valid=1, out_result=110, out_id=0, out_ovf=0.
REQ-033 Bench: req 2 valid with A=3, B=8 -> out_result=8, out_id=2; with A=B=16 -> out_result=20.
REQ-034 Bench: A=2^27-1, B=4 -> out_result=2^27-1, out_ovf=1.
REQ-035 Bench: all four req_valid held high with out_ready=1 -> grant order 0,1,2,3,0 and one accept every 3 cycles.
REQ-036 Bench: out_ready held low for 5 cycles in DONE -> outputs stable, req_ready=0000 and busy=1 throughout; the handshake on the 6th cycle returns the block to IDLE.
REQ-037 Bench: reset pulsed during CALC -> all outputs 0 at once, no out_valid for the aborted operation, and the next grant goes to requester 0.
